cmp_share_arbiter: RTL and testbench

//  Shares one 4-bit magnitude-compare datapath (gt/lt/eq) between NREQ requesters.

---
 rtl/cmp_share_arbiter.sv | 137 +++++++++++++
 tb/tb_cmp_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator (gt/lt/eq) among NREQ requesters.
// Build option: define CMP_SIGNED_EN for a two's-complement compare; unsigned otherwise.
module cmp_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WIDTH-1:0]  req_a,
    input  logic [NREQ*WIDTH-1:0]  req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_gt,
    output logic                   rsp_lt,
    output logic                   rsp_eq,
    input  logic                   rsp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

    localparam logic [IDW:0]   NREQ_X  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_rsp_valid;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [NREQ-1:0]   w_first;
    logic [IDW-1:0]    w_off_chain [NREQ+1];
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_winner;
    logic              w_any;
    logic [NREQ-1:0]   w_grant;
    logic              w_gt;
    logic              w_lt;
    logic              w_eq;

    // Rotate requests so bit 0 is the requester at ptr, then pick the first set bit.
    assign w_dbl = {req_valid, req_valid} >> r_ptr;
    assign w_rot = w_dbl[NREQ-1:0];
    assign w_off_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pri
            if (gi == 0) begin : g_first
                assign w_first[gi] = w_rot[gi];
            end else begin : g_rest
                assign w_first[gi] = w_rot[gi] & ~(|w_rot[gi-1:0]);
            end
            assign w_off_chain[gi+1] = w_off_chain[gi] | (w_first[gi] ? IDW'(gi) : '0);
        end
    endgenerate

    assign w_any    = |req_valid;
    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off_chain[NREQ]};
    assign w_winner = (w_sum >= NREQ_X) ? IDW'(w_sum - NREQ_X) : IDW'(w_sum);
    assign w_grant  = (r_state == S_IDLE && !rst && w_any) ? (NREQ'(1) << w_winner) : '0;

`ifdef CMP_SIGNED_EN
    assign w_gt = $signed(r_a) > $signed(r_b);
    assign w_lt = $signed(r_a) < $signed(r_b);
`else
    assign w_gt = r_a > r_b;
    assign w_lt = r_a < r_b;
`endif
    assign w_eq = (r_a == r_b);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_next = S_CMP;
            S_CMP:   w_state_next = S_RESP;
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_id <= w_winner;
                    r_a  <= req_a[w_winner*WIDTH +: WIDTH];
                    r_b  <= req_b[w_winner*WIDTH +: WIDTH];
                end
                S_CMP: begin
                    r_gt        <= w_gt;
                    r_lt        <= w_lt;
                    r_eq        <= w_eq;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_ptr       <= (r_id == LAST_ID) ? '0 : r_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_gt    = r_gt;
    assign rsp_lt    = r_lt;
    assign rsp_eq    = r_eq;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: expected results queued at grant, checked at response handshake.
module tb_cmp_share_arbiter;
    localparam int NREQ = 4, WIDTH = 4, IDW = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_gt, rsp_lt, rsp_eq;
    logic                  rsp_ready;

    cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference compare: returns {gt, lt, eq}.
    function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b);
        int ia, ib;
`ifdef CMP_SIGNED_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        if (ia > ib)      return 3'b100;
        else if (ia < ib) return 3'b010;
        else              return 3'b001;
    endfunction

    logic [4:0] exp_q[$];
    int         grant_ids[$];
    int         grant_cyc[$];
    int         last_gcyc = 0;
    logic       prev_valid = 1'b0;
    logic [4:0] last_rsp = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (req_ready != '0) begin
                check_val("grant_onehot", 32'($onehot(req_ready)), 32'd1);
                check_val("grant_has_valid", 32'(|(req_ready & req_valid)), 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        grant_ids.push_back(i);
                        grant_cyc.push_back(cyc);
                        last_gcyc = cyc;
                        exp_q.push_back({2'(i), model(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH])});
                        $display("grant id=%0d a=%0d b=%0d cycle=%0d", i,
                                 req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], cyc);
                    end
                end
            end
            if (rsp_valid && !prev_valid)
                check_val("latency", 32'(cyc - last_gcyc), 32'd2);
            if (rsp_valid) begin
                check_val("rsp_onehot", 32'($onehot({rsp_gt, rsp_lt, rsp_eq})), 32'd1);
                check_val("busy_no_ready", 32'(req_ready), 32'd0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("rsp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    last_rsp = {rsp_id, rsp_gt, rsp_lt, rsp_eq};
                    check_val("rsp", 32'(last_rsp), 32'(exp_q.pop_front()));
                    $display("response id=%0d gt=%0b lt=%0b eq=%0b cycle=%0d",
                             rsp_id, rsp_gt, rsp_lt, rsp_eq, cyc);
                end
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic wait_grant(input int id);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        check_val($sformatf("grant_wait%0d", id), 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid[id] = 1'b1;
        wait_grant(id);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
        end
        check_val("drain", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp_valid(input string tag);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check_val(tag, 32'(got), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check_val({tag, "_id"}, 32'(rsp_id), 32'd0);
        check_val({tag, "_flags"}, 32'({rsp_gt, rsp_lt, rsp_eq}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] snap;
        int order[5] = '{0, 1, 2, 3, 0};
        int n;
        bit got;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check_val("reset_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Basic compares
        issue(0, 4'd9, 4'd3); drain();
        check_val("t1_gt", 32'(last_rsp), 32'b00_100);
        issue(2, 4'd5, 4'd5); drain();
        check_val("t2_eq", 32'(last_rsp), 32'b10_001);
        issue(2, 4'd0, 4'd15); drain();
`ifdef CMP_SIGNED_EN
        check_val("t2_lt", 32'(last_rsp), 32'b10_100);
`else
        check_val("t2_lt", 32'(last_rsp), 32'b10_010);
`endif
        issue(1, 4'b1000, 4'b0111); drain();
`ifdef CMP_SIGNED_EN
        check_val("t6_sign", 32'(last_rsp), 32'b01_010);
`else
        check_val("t6_sign", 32'(last_rsp), 32'b01_100);
`endif

        // All four requesting continuously from a fresh reset
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        grant_ids.delete(); grant_cyc.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 4'(i * 3);
            req_b[i*WIDTH +: WIDTH] = 4'd6;
        end
        req_valid = '1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (grant_ids.size() >= 5) got = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = '0;
        check_val("rr_count", 32'(got), 32'd1);
        n = (grant_ids.size() < 5) ? grant_ids.size() : 5;
        for (int k = 0; k < n; k++) begin
            check_val($sformatf("rr_order%0d", k), 32'(grant_ids[k]), 32'(order[k]));
            if (k > 0) check_val($sformatf("rr_spacing%0d", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd3);
        end
        drain();

        // Backpressure in RESP; afterwards the pointer wraps 3 -> 0
        rsp_ready = 1'b0;
        issue(3, 4'd12, 4'd1);
        req_a[0 +: WIDTH] = 4'd1; req_b[0 +: WIDTH] = 4'd2; req_valid[0] = 1'b1;
        wait_rsp_valid("bp_valid");
        snap = {rsp_id, rsp_gt, rsp_lt, rsp_eq};
        check_val("bp_value", 32'(snap), 32'b11_100);
        repeat (5) begin
            @(negedge clk);
            check_val("hold_valid", 32'(rsp_valid), 32'd1);
            check_val("hold_rsp", 32'({rsp_id, rsp_gt, rsp_lt, rsp_eq}), 32'(snap));
            check_val("hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("bp_release_valid", 32'(rsp_valid), 32'd0);
        check_val("bp_wrap_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        drain();

        // Reset while in CMP
        issue(1, 4'd3, 4'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort_cmp");
        repeat (4) begin
            @(negedge clk);
            check_val("abort_cmp_silent", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        req_a[0 +: WIDTH] = 4'd2;  req_b[0 +: WIDTH] = 4'd2;
        req_a[3*WIDTH +: WIDTH] = 4'd1; req_b[3*WIDTH +: WIDTH] = 4'd9;
        req_valid = 4'b1001;
        @(negedge clk);
        check_val("abort_cmp_regrant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Reset while in RESP
        rsp_ready = 1'b0;
        issue(2, 4'd7, 4'd7);
        wait_rsp_valid("abort_resp_valid");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort_resp");
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        check_val("abort_resp_regrant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
